// File: rtl/branch_predictor_2bit.sv
// Branch target buffer with per-entry 2-bit saturating direction counters for the IF stage.
// Lookup is combinational; updates, invalidation and prediction statistics are clocked.
module branch_predictor_2bit #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 8,
  parameter int MODE       = 1,
  parameter int CNT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] readPC,
  output logic                 predictTaken,
  output logic [WORD_SIZE-1:0] predictResult,
  input  logic                 update,
  input  logic [WORD_SIZE-1:0] writePC,
  input  logic                 actualTaken,
  input  logic [WORD_SIZE-1:0] pcTarget,
  input  logic                 predTakenIn,
  input  logic [WORD_SIZE-1:0] predTargetIn,
  input  logic                 btbClear,
  output logic [CNT_BITS-1:0]  predictCount,
  output logic [CNT_BITS-1:0]  correctCount,
  output logic                 mispredict
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  if (INDEX_BITS + TAG_BITS > WORD_SIZE) begin : g_param_check
    $error("branch_predictor_2bit: INDEX_BITS + TAG_BITS exceeds WORD_SIZE");
  end

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [CNT_BITS-1:0] cnt_sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  logic                 valid_q  [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];

  logic [CNT_BITS-1:0]  pred_cnt_q, pred_cnt_d;
  logic [CNT_BITS-1:0]  corr_cnt_q, corr_cnt_d;
  logic                 mispredict_q, mispredict_d;

  logic [INDEX_BITS-1:0] ridx, widx;
  logic [TAG_BITS-1:0]   rtag, wtag;
  logic                  rhit, whit, correct;
  logic                  alloc, hit_upd;
  logic [1:0]            ctr_d;

  assign ridx = readPC[INDEX_BITS-1:0];
  assign rtag = readPC[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
  assign widx = writePC[INDEX_BITS-1:0];
  assign wtag = writePC[INDEX_BITS+TAG_BITS-1:INDEX_BITS];

  assign rhit          = valid_q[ridx] && (tag_q[ridx] == rtag);
  assign predictTaken  = rhit && ((MODE == 0) || ctr_q[ridx][1]);
  assign predictResult = predictTaken ? target_q[ridx] : readPC + WORD_SIZE'(1);

  // Clear suppresses every table write in its cycle; statistics still see the update.
  assign whit    = valid_q[widx] && (tag_q[widx] == wtag);
  assign alloc   = update && !btbClear && !whit && actualTaken;
  assign hit_upd = update && !btbClear && whit;
  assign ctr_d   = actualTaken ? ctr_inc(ctr_q[widx]) : ctr_dec(ctr_q[widx]);
  assign correct = (predTakenIn == actualTaken) && (!actualTaken || (predTargetIn == pcTarget));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (btbClear) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (alloc) begin
      valid_q[widx] <= 1'b1;
      ctr_q[widx]   <= 2'b10;
    end else if (hit_upd) begin
      ctr_q[widx] <= ctr_d;
    end
  end

  // Tag/target payload carries no reset; it is only observable behind a valid bit.
  always_ff @(posedge clk) begin
    if (reset_n && (alloc || (hit_upd && actualTaken))) begin
      tag_q[widx]    <= wtag;
      target_q[widx] <= pcTarget;
    end
  end

  always_comb begin
    pred_cnt_d   = pred_cnt_q;
    corr_cnt_d   = corr_cnt_q;
    mispredict_d = 1'b0;
    if (update) begin
      pred_cnt_d   = cnt_sat_inc(pred_cnt_q);
      mispredict_d = !correct;
      if (correct) corr_cnt_d = cnt_sat_inc(corr_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_cnt_q   <= '0;
      corr_cnt_q   <= '0;
      mispredict_q <= 1'b0;
    end else begin
      pred_cnt_q   <= pred_cnt_d;
      corr_cnt_q   <= corr_cnt_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign predictCount = pred_cnt_q;
  assign correctCount = corr_cnt_q;
  assign mispredict   = mispredict_q;

endmodule

// File: doc/branch_predictor_2bit.md
# branch_predictor_2bit

Parametrised branch target buffer with per-entry 2-bit saturating direction counters, replacing the always-taken BTB in the IF stage of the pipelined datapath. IF performs a combinational lookup on the current PC and receives a predicted next PC. ID or EX, once a branch/jump resolves, issues a single-cycle update strobe carrying the real outcome. The block also keeps saturating prediction statistics for WWD-based debug readout.

## Interface
- WORD_SIZE, 16, PC/target width
- INDEX_BITS, 8, entries = 2^INDEX_BITS; index = readPC[INDEX_BITS-1:0]
- TAG_BITS, 8, tag = PC[INDEX_BITS+TAG_BITS-1:INDEX_BITS]; INDEX_BITS+TAG_BITS <= WORD_SIZE (elaboration error otherwise)
- MODE, 1, 0: predict taken on any valid hit (legacy); 1: predict taken only when counter[1]=1
- CNT_BITS, 16, width of statistics counters
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- readPC  input  WORD_SIZE  PC being fetched in IF
- predictTaken  output  1  lookup hit and predicted taken
- predictResult  output  WORD_SIZE  predicted next PC: stored target if predictTaken, else readPC+1
- update  input  1  one-cycle strobe: a control instruction resolved this cycle
- writePC  input  WORD_SIZE  PC of the resolving instruction
- actualTaken  input  1  resolved direction (jumps always 1)
- pcTarget  input  WORD_SIZE  resolved target address
- predTakenIn  input  1  predictTaken value that was carried down with the instruction
- predTargetIn  input  WORD_SIZE  predictResult value carried with the instruction
- btbClear  input  1  synchronous invalidate of all entries
- predictCount  output  CNT_BITS  number of updates since reset
- correctCount  output  CNT_BITS  number of updates whose prediction was correct
- mispredict  output  1  registered, high for one cycle after an update whose prediction was wrong

## Operation
- Per entry: valid (1b), tag (TAG_BITS), target (WORD_SIZE), ctr (2b).
- Lookup (combinational): hit = valid[idx] && tag[idx]==readPC tag field. predictTaken = hit && (MODE==0 || ctr[idx][1]). readPC+1 wraps modulo 2^WORD_SIZE (16'hFFFF -> 16'h0000).
- Update, entry at writePC index:
  - miss and actualTaken: allocate/overwrite: valid=1, tag, target=pcTarget, ctr=2'b10.
  - miss and !actualTaken: no table change.
  - hit and actualTaken: target=pcTarget; ctr=min(ctr+1,3).
  - hit and !actualTaken: target unchanged; ctr=max(ctr-1,0). Entry remains valid even at ctr=0.
- Correctness: correct = (predTakenIn==actualTaken) && (!actualTaken || predTargetIn==pcTarget).
- Stats on every update: predictCount+1; correctCount+1 if correct; both saturate at all-ones independently. mispredict <= update && !correct; otherwise 0.
- btbClear: all valid<=0; tags/targets/ctrs untouched. If btbClear and update coincide, clear wins: no allocation in that cycle. Statistics still count the update.
- Tag aliasing on PC bits above INDEX_BITS+TAG_BITS is accepted behaviour.

## Timing
- Lookup: zero latency, purely combinational from table state and readPC.
- Update visible to lookups from the cycle after the strobe. When the same index is read and written in one cycle, the read returns the old contents.
- mispredict: 1-cycle latency after update, 1-cycle pulse; back-to-back updates produce back-to-back pulses.
- Reset (async, any time, including mid-update): all valid=0, all ctr=2'b01, predictCount=0, correctCount=0, mispredict=0. Hence predictTaken=0 and predictResult=readPC+1 immediately. An update coincident with reset is discarded.
- update with X-free inputs is the only write source; no stall input. The caller must qualify update with its own stage-write enable.

## Test plan
- Reset: reset_n=0 with readPC=16'h0040 -> predictTaken=0, predictResult=16'h0041, counters 0, mispredict 0; readPC=16'hFFFF -> predictResult=16'h0000.
- Allocation: update writePC=16'h0012, actualTaken=1, pcTarget=16'h0030, predTakenIn=0 -> next cycle mispredict=1, predictCount=1, correctCount=0. Then readPC=16'h0012 -> predictTaken=1, predictResult=16'h0030.
- Hysteresis (MODE=1): from ctr=2'b10, one not-taken update -> ctr 01, predictTaken=0. Two taken updates -> 11, taken. Five taken updates total -> stays 11. Three not-taken updates from 11 -> 00, valid still 1, predictTaken=0.
- Tag conflict: entry for 16'h0012 present; update writePC=16'h0112 taken target 16'h0200 -> readPC=16'h0012 misses (predictResult=16'h0013), 16'h0112 hits with 16'h0200. MODE=0 after a not-taken hit still predicts taken.
- Same-cycle read/write and clear: update and lookup on index 16'h0020 in the same cycle -> lookup shows old entry. btbClear together with a taken update -> all lookups miss next cycle, predictCount still increments.
- Saturation/reset mid-run: CNT_BITS=4, 20 correct updates -> predictCount=correctCount=4'hF. Assert reset_n low during an update strobe -> all state at reset values, no allocation survives.
